i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//   Slave-mode I2S receiver: recovers 16-bit stereo frames from an external bit_clock/word_select/sound_data
//   stream and presents each left/right pair to downstream logic (recording path, loopback test of NCO output).
//   Fully synchronous to clk (24.576 MHz); I2S pins are oversampled, never used as clocks.
// PARAMETERS
//   DATA_W       16  bits per channel slot; slot = DATA_W bits, frame = 2*DATA_W bit_clock periods
//   SYNC_STAGES  2   flops in each pin synchronizer (>=2)
//   SAMPLE_RISE  0   0: sample sound_data/word_select on bit_clock falling edge; 1: on rising edge
// PORTS
//   clk            in   1       system clock, 24.576 MHz
//   rst            in   1       synchronous reset, active-high
//   bit_clock      in   1       I2S serial clock, async to clk, <= clk/8
//   word_select    in   1       I2S WS, 0 = left, 1 = right
//   sound_data     in   1       I2S serial data, MSB first
//   left_sample    out  DATA_W  left word of the presented pair
//   right_sample   out  DATA_W  right word of the presented pair
//   sample_valid   out  1       pair available; held until accepted
//   sample_ready   in   1       downstream accepts pair when valid && ready
//   overrun        out  1       1-cycle pulse: new pair overwrote an unaccepted pair
//   framing_error  out  1       1-cycle pulse: slot length != DATA_W (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at posedge clk): all outputs 0, shift reg 0, bit count 0, state SYNC; mid-frame reset discards partial data.
//   Input path: bit_clock, word_select, sound_data each through SYNC_STAGES flops (equal delay); sample strobe = 1-cycle pulse
//     on selected edge of synchronized bit_clock. All logic below advances only on strobe cycles.
//   On strobe: shift reg <= {shift[DATA_W-2:0], sd}; bit_cnt increments (saturates at 2*DATA_W); ws_last <= ws.
//   Slot end = strobe where ws != ws_last: bit just shifted is the LSB of the channel named by ws_last (I2S one-bit WS lead);
//     word = shift[DATA_W-1:0] incl. that bit; bit_cnt reloads to 1 for next slot... counted bits per slot must equal DATA_W.
//   FSM: SYNC  -> on first ws 1->0 slot end go LEFT (no capture; partial slot discarded).
//        LEFT  -> on ws 0->1 slot end: latch word into left holding reg, go RIGHT.
//        RIGHT -> on ws 1->0 slot end: latch word as right, commit pair {left_hold, word} to outputs, go LEFT.
//   Commit: left_sample/right_sample update, sample_valid <= 1. If sample_valid was 1 and sample_ready=0 that cycle,
//     overrun pulses, data overwritten. Commit and acceptance in same cycle: acceptance consumes old pair, new pair
//     presented next cycle with sample_valid=1, no overrun.
//   Handshake: sample_valid && sample_ready -> sample_valid <= 0 next cycle (unless commit). Outputs stable while valid.
//   Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the pin-level sample edge carrying right LSB (4 at default).
//   Arithmetic: bit_cnt is $clog2(2*DATA_W)+1 bits, saturating; no wrap. Stuck bit_clock: no strobes, state held.
// CONFIGURATION
//   I2S_RX_FRAME_CHECK_EN defined: at each slot end, bit_cnt != DATA_W -> framing_error pulses, word discarded,
//     FSM returns to SYNC (left hold cleared). Saturated bit_cnt (WS stuck) also flags at the next slot end.
//   Not defined: framing_error tied 0; words captured regardless of slot length (last DATA_W bits).
// STRUCTURE
//   Package i2s_pkg: I2S_DATA_W = 16 localparam, rx_state_t enum {SYNC, LEFT, RIGHT}, I2S_FRAME_BITS = 2*I2S_DATA_W.
//   Sub-module i2s_pin_sync: SYNC_STAGES synchronizer for 3 pins + edge detect -> strobe, ws_s, sd_s.
//   Top: FSM, shift reg, bit_cnt, holding/output regs, handshake.
// TESTING
//   1 Reset mid-frame: rst=1 during slot bit 7 -> all outputs 0, state SYNC; first pair only after a full left+right frame.
//   2 Golden stream: BFM bclk = clk/16, data launched on bclk rise, L=16'hA55A R=16'h1234 -> valid with left=A55A,
//     right=1234, 4 clk after right LSB edge; ready=1 -> valid drops next cycle.
//   3 Backpressure: ready=0 for 2 frames (L=0001/R=0002 then L=0003/R=0004) -> overrun pulses once, outputs 0003/0004.
//   4 Simultaneous: ready=1 asserted in exact commit cycle -> old pair consumed, new pair valid next cycle, overrun=0.
//   5 Startup alignment: stream begins mid-right slot -> first presented pair is the first complete L/R frame, no garbage.
//   6 Frame check (I2S_RX_FRAME_CHECK_EN): 15-bit left slot -> framing_error pulse, no valid for that frame, resync,
//     next good frame L=7FFF R=8000 presented correctly; without macro framing_error stays 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the slave-mode I2S receiver.
package i2s_pkg;

    localparam int I2S_DATA_W     = 16;
    localparam int I2S_FRAME_BITS = 2 * I2S_DATA_W;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronizes the three I2S pins into clk and turns the chosen bit_clock edge into a 1-cycle strobe.
// ws_s/sd_s carry the same total delay as the strobe so they line up with it.
module i2s_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_RISE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_clock,
    input  logic word_select,
    input  logic sound_data,
    output logic strobe,
    output logic ws_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] ws_sync_r;
    logic [SYNC_STAGES-1:0] sd_sync_r;
    logic                   bclk_prev_r;

    // Synchronizer chains, edge detector and aligned data/ws registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_r <= '0;
            ws_sync_r   <= '0;
            sd_sync_r   <= '0;
            bclk_prev_r <= 1'b0;
            strobe      <= 1'b0;
            ws_s        <= 1'b0;
            sd_s        <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], bit_clock};
            ws_sync_r   <= {ws_sync_r[SYNC_STAGES-2:0], word_select};
            sd_sync_r   <= {sd_sync_r[SYNC_STAGES-2:0], sound_data};
            bclk_prev_r <= bclk_sync_r[SYNC_STAGES-1];
            if (SAMPLE_RISE != 0) begin
                strobe <= bclk_sync_r[SYNC_STAGES-1] & ~bclk_prev_r;
            end else begin
                strobe <= ~bclk_sync_r[SYNC_STAGES-1] & bclk_prev_r;
            end
            ws_s <= ws_sync_r[SYNC_STAGES-1];
            sd_s <= sd_sync_r[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver: oversampled pins, left/right word recovery, valid/ready pair output.
// Optional slot-length checking is enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_RISE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_clock,
    input  logic              word_select,
    input  logic              sound_data,
    output logic [DATA_W-1:0] left_sample,
    output logic [DATA_W-1:0] right_sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              framing_error
);

    localparam int SAT_CNT = (I2S_FRAME_BITS / I2S_DATA_W) * DATA_W;
    localparam int CNT_W   = $clog2(SAT_CNT) + 1;

    logic              strobe_s;
    logic              ws_s;
    logic              sd_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] word_s;
    logic [DATA_W-1:0] left_hold_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              ws_last_r;
    logic              slot_end_s;
    logic              slot_ok_s;
    logic              capture_left_s;
    logic              commit_s;
    logic              frame_bad_s;
    rx_state_t         state_r;
    rx_state_t         state_nxt_s;

    i2s_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .SAMPLE_RISE (SAMPLE_RISE)
    ) u_pin_sync (
        .clk         (clk),
        .rst         (rst),
        .bit_clock   (bit_clock),
        .word_select (word_select),
        .sound_data  (sound_data),
        .strobe      (strobe_s),
        .ws_s        (ws_s),
        .sd_s        (sd_s)
    );

    // A ws change marks the bit just sampled as the LSB of the channel that is ending
    assign slot_end_s = strobe_s & (ws_s != ws_last_r);
    assign word_s     = {shift_r[DATA_W-2:0], sd_s};

`ifdef I2S_RX_FRAME_CHECK_EN
    assign slot_ok_s = (bit_cnt_r == CNT_W'(DATA_W));
`else
    assign slot_ok_s = 1'b1;
`endif

    // Next-state and capture/commit decode, evaluated only at slot ends
    always_comb begin
        state_nxt_s    = state_r;
        capture_left_s = 1'b0;
        commit_s       = 1'b0;
        frame_bad_s    = 1'b0;
        if (slot_end_s) begin
            case (state_r)
                SYNC: begin
                    if (ws_last_r) begin
                        state_nxt_s = LEFT;
                    end else begin
                        state_nxt_s = SYNC;
                    end
                end
                LEFT: begin
                    if (!slot_ok_s) begin
                        frame_bad_s = 1'b1;
                        state_nxt_s = SYNC;
                    end else if (!ws_last_r) begin
                        capture_left_s = 1'b1;
                        state_nxt_s    = RIGHT;
                    end else begin
                        state_nxt_s = SYNC;
                    end
                end
                RIGHT: begin
                    if (!slot_ok_s) begin
                        frame_bad_s = 1'b1;
                        state_nxt_s = SYNC;
                    end else if (ws_last_r) begin
                        commit_s    = 1'b1;
                        state_nxt_s = LEFT;
                    end else begin
                        state_nxt_s = SYNC;
                    end
                end
                default: begin
                    state_nxt_s = SYNC;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Serial shift register, slot bit counter and left-word holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            ws_last_r   <= 1'b0;
            left_hold_r <= '0;
        end else if (strobe_s) begin
            shift_r   <= word_s;
            ws_last_r <= ws_s;
            if (ws_s != ws_last_r) begin
                bit_cnt_r <= CNT_W'(1);
            end else if (bit_cnt_r != CNT_W'(SAT_CNT)) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (capture_left_s) begin
                left_hold_r <= word_s;
            end else if (frame_bad_s) begin
                left_hold_r <= '0;
            end else begin
                left_hold_r <= left_hold_r;
            end
        end else begin
            shift_r     <= shift_r;
            bit_cnt_r   <= bit_cnt_r;
            ws_last_r   <= ws_last_r;
            left_hold_r <= left_hold_r;
        end
    end

    // Output pair, valid/ready handshake and status pulses; a commit wins over acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            left_sample   <= '0;
            right_sample  <= '0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= frame_bad_s;
            if (commit_s) begin
                left_sample  <= left_hold_r;
                right_sample <= word_s;
                sample_valid <= 1'b1;
                overrun      <= sample_valid & ~sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
                overrun      <= 1'b0;
            end else begin
                sample_valid <= sample_valid;
                overrun      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed self-checking bench for i2s_receiver: BFM drives bit_clock = clk/16, data launched on rise.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_clock;
    logic        word_select;
    logic        sound_data;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        framing_error;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int vrise_cnt = 0;
    int ovr_cnt   = 0;
    int ferr_cnt  = 0;
    logic valid_q = 1'b0;
    int base_v;

    i2s_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .bit_clock     (bit_clock),
        .word_select   (word_select),
        .sound_data    (sound_data),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .framing_error (framing_error)
    );

    always #20 clk = ~clk;

    // Event counters for valid rises and status pulses
    always @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= sample_valid;
            if (sample_valid && !valid_q) vrise_cnt <= vrise_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (framing_error) ferr_cnt <= ferr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic v, input logic [15:0] l, input logic [15:0] r);
        check({tag, ".valid"}, {31'd0, sample_valid}, {31'd0, v});
        check({tag, ".left"}, {16'd0, left_sample}, {16'd0, l});
        check({tag, ".right"}, {16'd0, right_sample}, {16'd0, r});
    endtask

    task automatic half_hi(input logic w, input logic d);
        bit_clock   = 1'b1;
        word_select = w;
        sound_data  = d;
        repeat (8) @(negedge clk);
    endtask

    task automatic half_lo();
        bit_clock = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bit(input logic w, input logic d);
        half_hi(w, d);
        half_lo();
    endtask

    task automatic send_word(input logic ch, input logic [15:0] w, input logic nxt);
        for (int i = 15; i >= 1; i--) send_bit(ch, w[i]);
        send_bit(nxt, w[0]);
    endtask

    // Full frame up to and including the falling (sampling) edge of the right LSB
    task automatic frame_to_edge(input logic [15:0] l, input logic [15:0] r);
        send_word(1'b0, l, 1'b1);
        for (int i = 15; i >= 1; i--) send_bit(1'b1, r[i]);
        half_hi(1'b0, r[0]);
        bit_clock = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bit_clock    = 1'b0;
        word_select  = 1'b0;
        sound_data   = 1'b0;
        sample_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_pair("reset", 1'b0, 16'h0000, 16'h0000);
        check("reset.overrun", {31'd0, overrun}, 32'd0);
        check("reset.framing_error", {31'd0, framing_error}, 32'd0);
        rst = 1'b0;

        // Test 1: a held pair, then reset mid-left-slot at bit 7
        sample_ready = 1'b0;
        send_word(1'b1, 16'h0000, 1'b0);
        send_word(1'b0, 16'h00FF, 1'b1);
        send_word(1'b1, 16'hFF00, 1'b0);
        check_pair("pre_reset", 1'b1, 16'h00FF, 16'hFF00);
        for (int i = 15; i >= 8; i--) send_bit(1'b0, 1'b1);
        half_hi(1'b0, 1'b1);
        bit_clock = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_pair("midframe_reset", 1'b0, 16'h0000, 16'h0000);
        check("midframe_reset.overrun", {31'd0, overrun}, 32'd0);
        repeat (7) @(negedge clk);
        sample_ready = 1'b1;
        base_v = vrise_cnt;
        for (int i = 6; i >= 1; i--) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_word(1'b1, 16'hFFFF, 1'b0);
        check("after_reset.no_pair", {31'd0, sample_valid}, 32'd0);
        check("after_reset.no_rise", vrise_cnt - base_v, 32'd0);

        // Test 2: golden frame, latency of 4 clk from right-LSB sampling edge
        frame_to_edge(16'hA55A, 16'h1234);
        repeat (3) @(negedge clk);
        check("golden.valid_at_3", {31'd0, sample_valid}, 32'd0);
        @(negedge clk);
        check_pair("golden_at_4", 1'b1, 16'hA55A, 16'h1234);
        @(negedge clk);
        check_pair("golden_accepted", 1'b0, 16'hA55A, 16'h1234);
        repeat (3) @(negedge clk);

        // Test 3: backpressure over two frames
        sample_ready = 1'b0;
        send_word(1'b0, 16'h0001, 1'b1);
        send_word(1'b1, 16'h0002, 1'b0);
        check_pair("bp_first", 1'b1, 16'h0001, 16'h0002);
        check("bp_first.no_overrun", ovr_cnt, 32'd0);
        frame_to_edge(16'h0003, 16'h0004);
        repeat (3) @(negedge clk);
        check("bp.overrun_at_3", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        check("bp.overrun_pulse", {31'd0, overrun}, 32'd1);
        check_pair("bp_second", 1'b1, 16'h0003, 16'h0004);
        @(negedge clk);
        check("bp.overrun_single", {31'd0, overrun}, 32'd0);
        check("bp.held_valid", {31'd0, sample_valid}, 32'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        check("bp.released", {31'd0, sample_valid}, 32'd0);
        repeat (2) @(negedge clk);

        // Test 4: acceptance in the exact commit cycle
        sample_ready = 1'b0;
        send_word(1'b0, 16'h0005, 1'b1);
        send_word(1'b1, 16'h0006, 1'b0);
        check_pair("simul_old", 1'b1, 16'h0005, 16'h0006);
        frame_to_edge(16'h0007, 16'h0008);
        repeat (3) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        check_pair("simul_new", 1'b1, 16'h0007, 16'h0008);
        check("simul.no_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        check("simul.consumed", {31'd0, sample_valid}, 32'd0);
        repeat (3) @(negedge clk);

        // Test 5: stream starts mid-right-slot after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_pair("startup_reset", 1'b0, 16'h0000, 16'h0000);
        base_v = vrise_cnt;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        check("startup.no_garbage", vrise_cnt - base_v, 32'd0);
        sample_ready = 1'b0;
        send_word(1'b0, 16'h1111, 1'b1);
        send_word(1'b1, 16'h2222, 1'b0);
        check_pair("startup_first", 1'b1, 16'h1111, 16'h2222);
        check("startup.one_rise", vrise_cnt - base_v, 32'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        check("startup.accepted", {31'd0, sample_valid}, 32'd0);

        // Test 6: 15-bit left slot, then a good frame
        base_v = vrise_cnt;
        for (int i = 14; i >= 1; i--) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_word(1'b1, 16'h5555, 1'b0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("short.no_pair", vrise_cnt - base_v, 32'd0);
        check("short.framing_error", ferr_cnt, 32'd1);
`else
        check("short.pair", vrise_cnt - base_v, 32'd1);
        check_pair("short_captured", 1'b0, 16'h7FFF, 16'h5555);
        check("short.no_framing_error", ferr_cnt, 32'd0);
`endif
        send_word(1'b0, 16'h7FFF, 1'b1);
        send_word(1'b1, 16'h8000, 1'b0);
        check_pair("resync_good", 1'b0, 16'h7FFF, 16'h8000);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("resync.rises", vrise_cnt - base_v, 32'd1);
        check("total.framing_errors", ferr_cnt, 32'd1);
`else
        check("resync.rises", vrise_cnt - base_v, 32'd2);
        check("total.framing_errors", ferr_cnt, 32'd0);
`endif
        check("total.overruns", ovr_cnt, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
